// File: rtl/harness_pkg.sv
// Shared definitions for the harness project-switch logic: sequencer states,
// default harness dimensions and the per-project reset mask helper.
package harness_pkg;

  localparam int DEFAULT_NUM_PROJECTS = 6;
  localparam int DEFAULT_IO_PADS      = 38;
  localparam int MAX_PROJECTS         = 256;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ISOLATE    = 3'd1,
    ST_RESET_HOLD = 3'd2,
    ST_RELEASE    = 3'd3,
    ST_ENABLE     = 3'd4
  } seq_state_e;

  // One-hot of an 8-bit project index; callers cast down to their project count.
  function automatic logic [MAX_PROJECTS-1:0] project_onehot(input logic [7:0] idx);
    project_onehot      = '0;
    project_onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/sequencer_timer.sv
// Loadable dwell down-counter. Holds at zero until reloaded.
module sequencer_timer #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] count;

  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/project_switch_sequencer.sv
// Sequences a safe hand-over of the user I/O pads between harness projects:
// isolate pads, hold resets, move the mux, release, then re-enable pads.
module project_switch_sequencer
  import harness_pkg::*;
#(
  parameter int NUM_PROJECTS  = DEFAULT_NUM_PROJECTS,
  parameter int IO_PADS       = DEFAULT_IO_PADS,
  parameter int SETTLE_CYCLES = 4,
  parameter int RESET_CYCLES  = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    req_valid,
  input  logic [7:0]              req_project,
  input  logic [IO_PADS-1:0]      req_oeb,
  output logic                    req_ready,
  output logic [7:0]              active_project,
  output logic [IO_PADS-1:0]      io_oeb,
  output logic [NUM_PROJECTS-1:0] project_reset,
  output logic                    done,
  output logic                    reject
);

  localparam int MAX_CYCLES = (SETTLE_CYCLES > RESET_CYCLES) ? SETTLE_CYCLES : RESET_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  // The counter is loaded at the entry edge, so a dwell of N cycles loads N-1.
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RESET_LOAD  = CNT_W'(RESET_CYCLES - 1);

  seq_state_e             state;
  seq_state_e             state_next;
  logic [7:0]             tgt_project;
  logic [IO_PADS-1:0]     tgt_oeb;
  logic                   accept;
  logic                   in_range;
  logic                   timer_load;
  logic [CNT_W-1:0]       timer_value;
  logic                   timer_zero;

  assign accept   = req_valid && req_ready && (state == ST_IDLE);
  assign in_range = {1'b0, req_project} < 9'(NUM_PROJECTS);

  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:       if (accept && in_range) state_next = ST_ISOLATE;
      ST_ISOLATE:    if (timer_zero)         state_next = ST_RESET_HOLD;
      ST_RESET_HOLD: if (timer_zero)         state_next = ST_RELEASE;
      ST_RELEASE:    if (timer_zero)         state_next = ST_ENABLE;
      ST_ENABLE:                             state_next = ST_IDLE;
      default:                               state_next = ST_IDLE;
    endcase
    timer_load  = (state_next != state);
    timer_value = (state_next == ST_RESET_HOLD) ? RESET_LOAD : SETTLE_LOAD;
  end

  sequencer_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load       (timer_load),
    .load_value (timer_value),
    .zero       (timer_zero)
  );

  // Outputs are updated on the edge that enters each state, so each state's
  // output values are visible for exactly the cycles it occupies.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      tgt_project    <= '0;
      tgt_oeb        <= '1;
      req_ready      <= 1'b1;
      active_project <= '0;
      io_oeb         <= '1;
      project_reset  <= ~NUM_PROJECTS'(1);
      done           <= 1'b0;
      reject         <= 1'b0;
    end else begin
      state  <= state_next;
      done   <= 1'b0;
      reject <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (in_range) begin
              tgt_project <= req_project;
              tgt_oeb     <= req_oeb;
              req_ready   <= 1'b0;
              io_oeb      <= '1;
            end else begin
              reject <= 1'b1;
            end
          end
        end
        ST_ISOLATE: begin
          if (timer_zero) begin
            active_project <= tgt_project;
            project_reset  <= '1;
          end
        end
        ST_RESET_HOLD: begin
          if (timer_zero) project_reset <= ~NUM_PROJECTS'(project_onehot(tgt_project));
        end
        ST_RELEASE: begin
          if (timer_zero) begin
            io_oeb <= tgt_oeb;
            done   <= 1'b1;
          end
        end
        ST_ENABLE: req_ready <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_project_switch_sequencer.sv
// Self-checking bench for project_switch_sequencer: vector table, directed
// corner sequences and random requests against a cycle-indexed reference model.
module tb_project_switch_sequencer;

  localparam int NP  = 6;
  localparam int IOP = 38;
  localparam int S   = 4;
  localparam int R   = 16;
  localparam int L   = 2 * S + R + 1;
  localparam logic [IOP-1:0] ONES = '1;

  logic             clk = 1'b0;
  logic             reset;
  logic             req_valid;
  logic [7:0]       req_project;
  logic [IOP-1:0]   req_oeb;
  logic             req_ready;
  logic [7:0]       active_project;
  logic [IOP-1:0]   io_oeb;
  logic [NP-1:0]    project_reset;
  logic             done;
  logic             reject;

  always #5 clk = ~clk;

  project_switch_sequencer #(
    .NUM_PROJECTS  (NP),
    .IO_PADS       (IOP),
    .SETTLE_CYCLES (S),
    .RESET_CYCLES  (R)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .req_valid      (req_valid),
    .req_project    (req_project),
    .req_oeb        (req_oeb),
    .req_ready      (req_ready),
    .active_project (active_project),
    .io_oeb         (io_oeb),
    .project_reset  (project_reset),
    .done           (done),
    .reject         (reject)
  );

  typedef struct {
    logic [7:0]     act;
    logic [IOP-1:0] oeb;
    logic [NP-1:0]  prst;
    logic           ready;
    logic           done;
    logic           reject;
  } exp_t;

  typedef struct {
    logic [7:0]     project;
    logic [IOP-1:0] oeb;
    logic           exp_reject;
  } vec_t;

  int             n_checks = 0;
  int             n_fail   = 0;
  logic [7:0]     cur_act;
  logic [IOP-1:0] cur_oeb;

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NP-1:0] running_mask(input logic [7:0] a);
    running_mask = ~(NP'(1) << a);
  endfunction

  // Expected outputs n cycles after a request for p (mask m) is accepted
  // while project old_a was active.
  function automatic exp_t model(input int n, input logic [7:0] old_a,
                                 input logic [7:0] p, input logic [IOP-1:0] m);
    exp_t e;
    e.act    = (n > S) ? p : old_a;
    e.oeb    = (n >= L) ? m : ONES;
    e.prst   = (n <= S) ? running_mask(old_a) : (n <= S + R) ? '1 : running_mask(p);
    e.ready  = (n > L);
    e.done   = (n == L);
    e.reject = 1'b0;
    return e;
  endfunction

  function automatic exp_t idle_exp(input logic rej);
    exp_t e;
    e.act    = cur_act;
    e.oeb    = cur_oeb;
    e.prst   = running_mask(cur_act);
    e.ready  = 1'b1;
    e.done   = 1'b0;
    e.reject = rej;
    return e;
  endfunction

  task automatic compare_all(input string tag, input exp_t e);
    check({tag, " active_project"}, 64'(active_project), 64'(e.act));
    check({tag, " io_oeb"},         64'(io_oeb),         64'(e.oeb));
    check({tag, " project_reset"},  64'(project_reset),  64'(e.prst));
    check({tag, " req_ready"},      64'(req_ready),      64'(e.ready));
    check({tag, " done"},           64'(done),           64'(e.done));
    check({tag, " reject"},         64'(reject),         64'(e.reject));
  endtask

  // Full switch; optionally raises (and leaves held) a new request in cycle inject_at.
  task automatic run_switch(input logic [7:0] p, input logic [IOP-1:0] m,
                            input int inject_at, input logic [7:0] ip,
                            input logic [IOP-1:0] im, output int rst_cycles);
    req_valid   = 1'b1;
    req_project = p;
    req_oeb     = m;
    step();
    req_valid  = 1'b0;
    rst_cycles = 0;
    for (int n = 1; n <= L + 1; n++) begin
      if (n > 1) step();
      if (n == inject_at) begin
        req_valid   = 1'b1;
        req_project = ip;
        req_oeb     = im;
      end
      compare_all($sformatf("sw p%0d c%0d", p, n), model(n, cur_act, p, m));
      if (n <= L && project_reset[p[2:0]]) rst_cycles++;
    end
    cur_act = p;
    cur_oeb = m;
  endtask

  task automatic run_reject(input logic [7:0] p);
    req_valid   = 1'b1;
    req_project = p;
    req_oeb     = IOP'({$urandom, $urandom});
    step();
    req_valid = 1'b0;
    compare_all($sformatf("rej p%0d c1", p), idle_exp(1'b1));
    step();
    compare_all($sformatf("rej p%0d c2", p), idle_exp(1'b0));
  endtask

  initial begin
    vec_t vecs[8];
    int   rc;
    logic done_seen;

    vecs[0] = '{project: 8'd7,   oeb: 38'h00_0000_0000, exp_reject: 1'b1};
    vecs[1] = '{project: 8'd5,   oeb: 38'h2A_AAAA_AAAA, exp_reject: 1'b0};
    vecs[2] = '{project: 8'd6,   oeb: 38'h15_5555_5555, exp_reject: 1'b1};
    vecs[3] = '{project: 8'd0,   oeb: 38'h3F_FFFF_FFFF, exp_reject: 1'b0};
    vecs[4] = '{project: 8'd255, oeb: 38'h00_0000_0001, exp_reject: 1'b1};
    vecs[5] = '{project: 8'd1,   oeb: 38'h20_0000_0000, exp_reject: 1'b0};
    vecs[6] = '{project: 8'd128, oeb: 38'h12_3456_789A, exp_reject: 1'b1};
    vecs[7] = '{project: 8'd4,   oeb: 38'h0F_0F0F_0F0F, exp_reject: 1'b0};

    reset       = 1'b1;
    req_valid   = 1'b0;
    req_project = '0;
    req_oeb     = '0;
    repeat (3) step();
    reset = 1'b0;
    cur_act = 8'd0;
    cur_oeb = ONES;
    compare_all("post-reset", idle_exp(1'b0));
    check("post-reset io_oeb literal", 64'(io_oeb), 64'(38'h3F_FFFF_FFFF));
    check("post-reset project_reset literal", 64'(project_reset), 64'(6'b111110));

    // Normal switch 0 -> 3
    run_switch(8'd3, 38'h00_0000_00FF, 0, 8'd0, '0, rc);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].exp_reject) run_reject(vecs[i].project);
      else run_switch(vecs[i].project, vecs[i].oeb, 0, 8'd0, '0, rc);
    end

    // Same-project restart of project 4 (active after the table)
    check("restart precondition active", 64'(active_project), 64'(8'd4));
    run_switch(8'd4, 38'h3C_3C3C_3C3C, 0, 8'd0, '0, rc);
    check("restart reset[4] cycles", 64'(rc), 64'(R));

    // Request raised mid-switch is ignored, then taken back-to-back
    run_switch(8'd2, 38'h01_2345_6789, 10, 8'd1, 38'h3E_DCBA_9876, rc);
    run_switch(8'd1, 38'h3E_DCBA_9876, 0, 8'd0, '0, rc);

    // Reset in cycle 12 of a switch to project 2
    req_valid   = 1'b1;
    req_project = 8'd2;
    req_oeb     = 38'h00_FFFF_0000;
    step();
    req_valid = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      if (n > 1) step();
      compare_all($sformatf("abort c%0d", n), model(n, cur_act, 8'd2, 38'h00_FFFF_0000));
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    cur_act = 8'd0;
    cur_oeb = ONES;
    compare_all("abort reset values", idle_exp(1'b0));
    done_seen = 1'b0;
    for (int n = 0; n < L + 5; n++) begin
      step();
      if (done) done_seen = 1'b1;
    end
    check("abort no done", 64'(done_seen), 64'(1'b0));
    compare_all("abort idle", idle_exp(1'b0));

    // Random requests
    for (int i = 0; i < 20; i++) begin
      logic [7:0]     p;
      logic [IOP-1:0] m;
      p = 8'($urandom_range(0, 9));
      m = IOP'({$urandom, $urandom});
      if (p >= NP) run_reject(p);
      else run_switch(p, m, 0, 8'd0, '0, rc);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
